// File: rtl/m_bus_unit.sv
// rtl/m_bus_unit.sv - 8085-style memory bus initiator for the M pseudo-register
module m_bus_unit #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       we,
    input  logic [7:0] h_in,
    input  logic [7:0] l_in,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] a_hi,
    output logic [7:0] ad_out,
    input  logic [7:0] ad_in,
    output logic       ad_oe,
    output logic       ale,
    output logic       rd_n,
    output logic       wr_n,
    output logic       io_m,
    output logic       s1,
    output logic       s0,
    input  logic       ready
);

    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_TW,
        S_T3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       we_q, we_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [7:0] a_hi_q, a_hi_d;
    logic [7:0] ad_out_q, ad_out_d;
    logic       ad_oe_q, ad_oe_d;
    logic       ale_q, ale_d;
    logic       rd_n_q, rd_n_d;
    logic       wr_n_q, wr_n_d;
    logic       s1_q, s1_d;
    logic       s0_q, s0_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'h00;
            we_q     <= 1'b0;
            wdata_q  <= 8'h00;
            rdata_q  <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            a_hi_q   <= 8'h00;
            ad_out_q <= 8'h00;
            ad_oe_q  <= 1'b0;
            ale_q    <= 1'b0;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            s1_q     <= 1'b0;
            s0_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            a_hi_q   <= a_hi_d;
            ad_out_q <= ad_out_d;
            ad_oe_q  <= ad_oe_d;
            ale_q    <= ale_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            s1_q     <= s1_d;
            s0_q     <= s0_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        a_hi_d   = a_hi_q;
        ad_out_d = ad_out_q;
        ad_oe_d  = ad_oe_q;
        ale_d    = ale_q;
        rd_n_d   = rd_n_q;
        wr_n_d   = wr_n_q;
        s1_d     = s1_q;
        s0_d     = s0_q;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d     = we;
                    wdata_d  = wdata;
                    a_hi_d   = h_in;
                    ad_out_d = l_in;
                    ad_oe_d  = 1'b1;
                    ale_d    = 1'b1;
                    busy_d   = 1'b1;
                    s1_d     = ~we;
                    s0_d     = we;
                    cnt_d    = 8'h00;
                    state_d  = S_T1;
                end
            end
            S_T1: begin
                // Address phase ends: the AD bus turns around for a read or carries data for a write
                ale_d = 1'b0;
                if (we_q) begin
                    ad_out_d = wdata_q;
                    wr_n_d   = 1'b0;
                end else begin
                    ad_oe_d = 1'b0;
                    rd_n_d  = 1'b0;
                end
                state_d = S_T2;
            end
            S_T2: begin
                if (ready) begin
                    state_d = S_T3;
                end else begin
                    cnt_d   = 8'h01;
                    state_d = S_TW;
                end
            end
            S_TW: begin
                if (ready) begin
                    state_d = S_T3;
                end else if (cnt_q == WAIT_LIMIT) begin
                    rd_n_d  = 1'b1;
                    wr_n_d  = 1'b1;
                    ad_oe_d = 1'b0;
                    s1_d    = 1'b0;
                    s0_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'h01;
                end
            end
            S_T3: begin
                if (!we_q) begin
                    rdata_d = ad_in;
                end
                rd_n_d  = 1'b1;
                wr_n_d  = 1'b1;
                ad_oe_d = 1'b0;
                s1_d    = 1'b0;
                s0_d    = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rdata  = rdata_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign a_hi   = a_hi_q;
    assign ad_out = ad_out_q;
    assign ad_oe  = ad_oe_q;
    assign ale    = ale_q;
    assign rd_n   = rd_n_q;
    assign wr_n   = wr_n_q;
    assign io_m   = 1'b0;
    assign s1     = s1_q;
    assign s0     = s0_q;

endmodule

// File: tb/tb_m_bus_unit.sv
// tb/tb_m_bus_unit.sv - directed self-checking bench for m_bus_unit
module tb_m_bus_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       we;
    logic [7:0] h_in;
    logic [7:0] l_in;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] a_hi;
    logic [7:0] ad_out;
    logic [7:0] ad_in;
    logic       ad_oe;
    logic       ale;
    logic       rd_n;
    logic       wr_n;
    logic       io_m;
    logic       s1;
    logic       s0;
    logic       ready;

    int checks   = 0;
    int failures = 0;

    m_bus_unit #(.WAIT_MAX(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .h_in   (h_in),
        .l_in   (l_in),
        .wdata  (wdata),
        .rdata  (rdata),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .a_hi   (a_hi),
        .ad_out (ad_out),
        .ad_in  (ad_in),
        .ad_oe  (ad_oe),
        .ale    (ale),
        .rd_n   (rd_n),
        .wr_n   (wr_n),
        .io_m   (io_m),
        .s1     (s1),
        .s0     (s0),
        .ready  (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int low_cnt;
        int done_at;

        rst = 1'b0; req = 1'b0; we = 1'b0; h_in = 8'h00; l_in = 8'h00;
        wdata = 8'h00; ad_in = 8'h00; ready = 1'b1;

        // reset values
        tick(); tick();
        chk("rst_rd_n", 8'(rd_n), 8'h1);
        chk("rst_wr_n", 8'(wr_n), 8'h1);
        chk("rst_ad_oe", 8'(ad_oe), 8'h0);
        chk("rst_busy", 8'(busy), 8'h0);
        chk("rst_rdata", rdata, 8'h00);
        rst = 1'b1;
        tick();
        chk("post_rst_done", 8'(done), 8'h0);
        chk("post_rst_io_m", 8'(io_m), 8'h0);
        chk("post_rst_status", {6'b0, s1, s0}, 8'h0);

        // zero-wait read
        h_in = 8'h20; l_in = 8'h50; we = 1'b0; ad_in = 8'hA5; req = 1'b1;
        tick();
        req = 1'b0; h_in = 8'hFF;
        chk("rd_t1_a_hi", a_hi, 8'h20);
        chk("rd_t1_ad_out", ad_out, 8'h50);
        chk("rd_t1_ale", 8'(ale), 8'h1);
        chk("rd_t1_status", {6'b0, s1, s0}, 8'h2);
        chk("rd_t1_busy", 8'(busy), 8'h1);
        tick();
        chk("rd_t2_ale", 8'(ale), 8'h0);
        chk("rd_t2_rd_n", 8'(rd_n), 8'h0);
        chk("rd_t2_ad_oe", 8'(ad_oe), 8'h0);
        tick();
        chk("rd_t3_rd_n", 8'(rd_n), 8'h0);
        chk("rd_t3_a_hi", a_hi, 8'h20);
        chk("rd_t3_done", 8'(done), 8'h0);
        tick();
        chk("rd_done", 8'(done), 8'h1);
        chk("rd_err", 8'(err), 8'h0);
        chk("rd_rdata", rdata, 8'hA5);
        chk("rd_end_rd_n", 8'(rd_n), 8'h1);
        chk("rd_end_busy", 8'(busy), 8'h0);
        tick();
        chk("rd_done_pulse", 8'(done), 8'h0);

        // zero-wait write
        h_in = 8'h12; l_in = 8'h34; wdata = 8'h5A; we = 1'b1; req = 1'b1;
        tick();
        req = 1'b0;
        chk("wr_t1_ad_out", ad_out, 8'h34);
        chk("wr_t1_status", {6'b0, s1, s0}, 8'h1);
        tick();
        chk("wr_t2_ad_out", ad_out, 8'h5A);
        chk("wr_t2_wr_n", 8'(wr_n), 8'h0);
        chk("wr_t2_ad_oe", 8'(ad_oe), 8'h1);
        chk("wr_t2_rd_n", 8'(rd_n), 8'h1);
        tick();
        chk("wr_t3_wr_n", 8'(wr_n), 8'h0);
        tick();
        chk("wr_done", 8'(done), 8'h1);
        chk("wr_err", 8'(err), 8'h0);
        chk("wr_rdata_kept", rdata, 8'hA5);
        chk("wr_end_wr_n", 8'(wr_n), 8'h1);

        // three wait states
        h_in = 8'h40; l_in = 8'h01; we = 1'b0; ad_in = 8'h3C; req = 1'b1; ready = 1'b0;
        tick();
        req = 1'b0;
        low_cnt = 0; done_at = 0;
        for (k = 2; k <= 20 && done_at == 0; k++) begin
            tick();
            if (!rd_n) low_cnt++;
            if (done) done_at = k;
            if (k >= 5) ready = 1'b1;
        end
        chk("ws_done_cycle", 8'(done_at), 8'd7);
        chk("ws_rd_n_low_cycles", 8'(low_cnt), 8'd5);
        chk("ws_err", 8'(err), 8'h0);
        chk("ws_rdata", rdata, 8'h3C);
        tick();

        // timeout with WAIT_MAX = 4
        h_in = 8'h41; l_in = 8'h02; we = 1'b0; ad_in = 8'hEE; req = 1'b1; ready = 1'b0;
        tick();
        req = 1'b0;
        done_at = 0;
        for (k = 2; k <= 20 && done_at == 0; k++) begin
            tick();
            if (done) done_at = k;
        end
        chk("to_done_cycle", 8'(done_at), 8'd7);
        chk("to_err", 8'(err), 8'h1);
        chk("to_rd_n", 8'(rd_n), 8'h1);
        chk("to_ad_oe", 8'(ad_oe), 8'h0);
        chk("to_rdata_kept", rdata, 8'h3C);
        chk("to_busy", 8'(busy), 8'h0);
        ready = 1'b1;
        tick();
        chk("to_err_cleared", 8'(err), 8'h0);

        // back-to-back write then read, inputs changed after acceptance
        h_in = 8'hAA; l_in = 8'h01; wdata = 8'h77; we = 1'b1; req = 1'b1; ad_in = 8'h99;
        tick();
        h_in = 8'hBB; l_in = 8'h02; we = 1'b0; wdata = 8'h00;
        chk("bb_t1_a_hi", a_hi, 8'hAA);
        tick();
        chk("bb_t2_a_hi", a_hi, 8'hAA);
        chk("bb_t2_wr_n", 8'(wr_n), 8'h0);
        chk("bb_t2_ad_out", ad_out, 8'h77);
        tick();
        tick();
        chk("bb_first_done", 8'(done), 8'h1);
        chk("bb_first_idle_busy", 8'(busy), 8'h0);
        tick();
        req = 1'b0;
        chk("bb_second_t1_a_hi", a_hi, 8'hBB);
        chk("bb_second_t1_ale", 8'(ale), 8'h1);
        chk("bb_second_status", {6'b0, s1, s0}, 8'h2);
        tick(); tick(); tick();
        chk("bb_second_done", 8'(done), 8'h1);
        chk("bb_second_rdata", rdata, 8'h99);

        // reset asserted mid-TW
        h_in = 8'h50; l_in = 8'h60; we = 1'b0; req = 1'b1; ready = 1'b0;
        tick();
        req = 1'b0;
        tick(); tick();
        chk("mid_tw_rd_n", 8'(rd_n), 8'h0);
        #2 rst = 1'b0;
        #1;
        chk("async_rd_n", 8'(rd_n), 8'h1);
        chk("async_ad_oe", 8'(ad_oe), 8'h0);
        chk("async_busy", 8'(busy), 8'h0);
        tick();
        rst = 1'b1; ready = 1'b1;
        done_at = 0;
        for (k = 0; k < 6; k++) begin
            tick();
            if (done) done_at = 1;
        end
        chk("no_done_after_abort", 8'(done_at), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/m_bus_unit.md
Name: m_bus_unit

Overview:
- Bus initiator that services the M pseudo-register (code 3'b110) for the register file.
- Takes H and L as the 16-bit address.
- Runs one 8085-style machine cycle (T1/T2/TW/T3) on the multiplexed external address/data bus:
  - a memory read delivers the byte in rdata;
  - a memory write drives wdata onto the bus.
- Sits between the control unit/register file and external memory.
- Inserts wait states on READY and aborts on a bounded wait timeout.

Parameters:
- WAIT_MAX, 15: maximum TW cycles before abort; range 1..255.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset; 0 = reset asserted.
- req  in  1  start request, sampled only in IDLE.
- we  in  1  1 = write M, 0 = read M; captured with req.
- h_in  in  8  register H, address high byte; captured with req.
- l_in  in  8  register L, address low byte; captured with req.
- wdata  in  8  byte to write; captured with req.
- rdata  out  8  last byte read.
- busy  out  1  high from the cycle after acceptance through T3.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done; 1 = timeout abort.
- a_hi  out  8  upper address bus A15..A8.
- ad_out  out  8  multiplexed AD7..AD0, output side.
- ad_in  in  8  multiplexed AD7..AD0, input side.
- ad_oe  out  1  AD output enable.
- ale  out  1  address latch enable.
- rd_n  out  1  read strobe, active low.
- wr_n  out  1  write strobe, active low.
- io_m  out  1  always 0 (memory space).
- s1  out  1  status bit S1.
- s0  out  1  status bit S0.
- ready  in  1  memory ready; 0 inserts wait states.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE.
  - rdata=0, busy=0, done=0, err=0.
  - a_hi=0, ad_out=0, ad_oe=0, ale=0, rd_n=1, wr_n=1, io_m=0, s1=0, s0=0.
  - Wait counter=0.
  - Reset mid-cycle drops all strobes immediately. No done is produced for the aborted cycle.
- All outputs are registered. States: IDLE, T1, T2, TW, T3.
- IDLE:
  - Strobes inactive, ad_oe=0, s1/s0=00.
  - req=1 latches we, h_in, l_in, wdata → T1.
  - req while busy is ignored; there is no queueing.
- T1 (1 cycle):
  - a_hi=H, ad_out=L, ad_oe=1, ale=1, busy=1.
  - Status: read s1s0=10, write s1s0=01 (held through T3). → T2.
- T2 (1 cycle): ale=0.
  - Read: ad_oe=0, rd_n=0.
  - Write: ad_out=wdata, ad_oe=1, wr_n=0.
  - ready sampled at end of T2: 1 → T3; 0 → TW, counter=1.
- TW:
  - Bus and strobes held as in T2.
  - ready=1 at end of cycle → T3.
  - If ready=0 and counter==WAIT_MAX → abort: go to IDLE, drop strobes, done=1, err=1, rdata unchanged.
  - Otherwise counter+1.
- T3 (1 cycle): strobes still active. At the closing edge:
  - Read: rdata ← ad_in.
  - Both directions: rd_n/wr_n ← 1, ad_oe ← 0, s1s0 ← 00, busy ← 0, done ← 1, err ← 0 → IDLE.
- Latency:
  - Zero-wait cycle: req accepted on edge E; done high in the cycle after E+3 edges, i.e. 4 cycles from acceptance.
  - Each wait state adds 1 cycle.
- done cycle is IDLE, so a req asserted then is accepted; back-to-back cycles cost 4 clocks each.
- Inputs h_in/l_in/wdata/we may change freely after acceptance without affecting the cycle.
- ready is ignored outside T2/TW.
- Counter resets to 0 on every entry to T1.
- err is valid only while done=1; it is 0 otherwise.

Test Plan:
- Reset values: hold rst=0, then release → all outputs at reset values. Assert rst=0 mid-TW → rd_n=1 and ad_oe=0 asynchronously; no done pulse.
- Zero-wait read: H=8'h20, L=8'h50, we=0, ready=1, ad_in=8'hA5 in T3 → T1: a_hi=20, ad_out=50, ale=1, s1s0=10. T2–T3: rd_n=0. done on cycle 4 with rdata=A5, err=0.
- Zero-wait write: H=8'h12, L=8'h34, wdata=8'h5A → ad_out=5A with wr_n=0 for T2–T3, s1s0=01, done with err=0. rdata unchanged.
- Wait states: read with ready=0 for 3 cycles → exactly 3 TW cycles, rd_n held low, done on cycle 7.
- Timeout: WAIT_MAX=4, ready held 0 → done=1, err=1 after 4 TW cycles. Strobes released, previous rdata retained.
- Back-to-back and change-after-accept: req high continuously, write then read → second T1 starts the cycle after done. Changing h_in after acceptance does not alter a_hi during the first cycle.
